// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for the immediate-extension stage: upstream immediate,
// downstream extended result, flush and the completed-transfer counter.
interface imm_extend_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] xfer_count;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, flush, out_ready,
        input  in_ready, out_valid, out_data, out_tag, xfer_count
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, flush, out_ready,
        output in_ready, out_valid, out_data, out_tag, xfer_count
    );
endinterface

// File: rtl/imm_extend_stage.sv
// Immediate sign/zero/upper/branch extension stage with an output register
// plus one skid register, flush, and a saturating output-transfer counter.
module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    imm_extend_stage_if.slave bus
);
    if (OUT_W < IN_W + 2) begin : g_widthCheck
        $error("imm_extend_stage: OUT_W must be at least IN_W+2");
    end

    // Bit 0 of the state is out_valid and bit 1 is skid_valid, so both flags
    // come straight from flops; the encoding 2'b10 is never entered.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    state_t           r_state;
    logic [OUT_W-1:0] r_outData;
    logic [TAG_W-1:0] r_outTag;
    logic [OUT_W-1:0] r_skidData;
    logic [TAG_W-1:0] r_skidTag;
    logic [CNT_W-1:0] r_xferCount;

    logic [OUT_W-1:0] w_signExt;
    logic [OUT_W-1:0] w_zeroExt;
    logic [OUT_W-1:0] w_upperExt;
    logic [OUT_W-1:0] w_branchExt;
    logic [OUT_W-1:0] w_extData;
    logic             w_inReady;
    logic             w_inXfer;
    logic             w_outXfer;

    assign w_signExt   = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
    assign w_zeroExt   = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};
    assign w_upperExt  = {bus.in_imm, {(OUT_W-IN_W){1'b0}}};
    assign w_branchExt = {w_signExt[OUT_W-3:0], 2'b00};

    always_comb begin
        w_extData = w_signExt;
        case (bus.in_mode)
            2'b00:   w_extData = w_signExt;
            2'b01:   w_extData = w_zeroExt;
            2'b10:   w_extData = w_upperExt;
            default: w_extData = w_branchExt;
        endcase
    end

    assign w_inReady = !r_state[1] && !reset;
    assign w_inXfer  = bus.in_valid && w_inReady;
    assign w_outXfer = r_state[0] && bus.out_ready;

    // Entries are stored already extended; flush drops them but a drain in
    // the same cycle is still counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_outData   <= '0;
            r_outTag    <= '0;
            r_skidData  <= '0;
            r_skidTag   <= '0;
            r_xferCount <= '0;
        end else begin
            if (w_outXfer && (r_xferCount != {CNT_W{1'b1}})) begin
                r_xferCount <= r_xferCount + 1'b1;
            end

            if (bus.flush) begin
                r_state <= S_EMPTY;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_inXfer) begin
                            r_outData <= w_extData;
                            r_outTag  <= bus.in_tag;
                            r_state   <= S_ONE;
                        end
                    end
                    S_ONE: begin
                        if (w_inXfer && w_outXfer) begin
                            r_outData <= w_extData;
                            r_outTag  <= bus.in_tag;
                        end else if (w_inXfer) begin
                            r_skidData <= w_extData;
                            r_skidTag  <= bus.in_tag;
                            r_state    <= S_FULL;
                        end else if (w_outXfer) begin
                            r_state <= S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        if (w_outXfer) begin
                            r_outData <= r_skidData;
                            r_outTag  <= r_skidTag;
                            r_state   <= S_ONE;
                        end
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = r_state[0];
    assign bus.out_data   = r_outData;
    assign bus.out_tag    = r_outTag;
    assign bus.xfer_count = r_xferCount;
endmodule

// File: tb/tb_imm_extend_stage.sv
// Self-checking bench for imm_extend_stage: extension vectors, skid/flush/reset
// sequences, counter saturation, and random traffic against a queue model.
module tb_imm_extend_stage;
    logic clk;
    logic reset;

    imm_extend_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(5), .CNT_W(16)) busA ();
    imm_extend_stage_if #(.IN_W(16), .OUT_W(32), .TAG_W(5), .CNT_W(2))  busC ();

    imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (busA.slave)
    );

    imm_extend_stage #(.IN_W(16), .OUT_W(32), .TAG_W(5), .CNT_W(2)) dutC (
        .clk   (clk),
        .reset (reset),
        .bus   (busC.slave)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] imm;
        logic [4:0]  tag;
        logic [31:0] expData;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } entry_t;

    int     vectors;
    int     miscompares;
    vec_t   vecs[9];
    entry_t modelQ[$];
    int     modelCount;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference extension from arithmetic on the immediate's value.
    function automatic logic [31:0] refExt(input logic [1:0] mode, input logic [15:0] imm);
        longint u;
        longint s;
        longint r;
        u = longint'(imm);
        s = (u >= 32768) ? u - 65536 : u;
        case (mode)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = u * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] imm, input logic [1:0] mode,
                                 input logic [4:0] tag, input logic outReady, input logic flush);
        busA.in_valid  = valid;
        busA.in_imm    = imm;
        busA.in_mode   = mode;
        busA.in_tag    = tag;
        busA.out_ready = outReady;
        busA.flush     = flush;
    endtask

    task automatic applyReset();
        applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        modelQ.delete();
        modelCount = 0;
    endtask

    initial begin
        int cntExp[5];
        logic [31:0] prevData;
        logic [4:0]  prevTag;
        logic        prevHeld;
        logic        inX;
        logic        outX;
        entry_t      e;

        vectors     = 0;
        miscompares = 0;
        modelCount  = 0;
        busC.in_valid  = 1'b0;
        busC.in_imm    = 16'h0;
        busC.in_mode   = 2'd0;
        busC.in_tag    = 5'd0;
        busC.out_ready = 1'b0;
        busC.flush     = 1'b0;

        vecs[0] = '{2'd0, 16'h8004, 5'd1,  32'hFFFF8004};
        vecs[1] = '{2'd1, 16'h8004, 5'd2,  32'h00008004};
        vecs[2] = '{2'd2, 16'h8004, 5'd3,  32'h80040000};
        vecs[3] = '{2'd3, 16'h8004, 5'd4,  32'hFFFE0010};
        vecs[4] = '{2'd0, 16'h7FFF, 5'd5,  32'h00007FFF};
        vecs[5] = '{2'd1, 16'hFFFF, 5'd6,  32'h0000FFFF};
        vecs[6] = '{2'd3, 16'h0001, 5'd7,  32'h00000004};
        vecs[7] = '{2'd3, 16'hFFFF, 5'd30, 32'hFFFFFFFC};
        vecs[8] = '{2'd2, 16'h1234, 5'd31, 32'h12340000};

        // Reset state, including in_ready held low while reset is high.
        applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        checkOutput("rst_out_valid", busA.out_valid, 0);
        checkOutput("rst_out_data", busA.out_data, 0);
        checkOutput("rst_xfer_count", busA.xfer_count, 0);
        checkOutput("rst_in_ready_during", busA.in_ready, 0);
        reset = 1'b0;
        #1;
        checkOutput("rst_in_ready_after", busA.in_ready, 1);

        // Extension table, one cycle latency with out_ready high.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].imm, vecs[i].mode, vecs[i].tag, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("vec%0d_valid", i), busA.out_valid, 1);
            checkOutput($sformatf("vec%0d_data", i), busA.out_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d_tag", i), busA.out_tag, vecs[i].tag);
            applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("vec%0d_drained", i), busA.out_valid, 0);
        end
        checkOutput("vec_xfer_count", busA.xfer_count, 9);

        // Backpressure: A in output, B in skid, then drain in order.
        applyReset();
        applyStimulus(1'b1, 16'h0001, 2'd1, 5'd1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0002, 2'd1, 5'd2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b0, 1'b0);
        checkOutput("skid_a_data", busA.out_data, 32'h1);
        checkOutput("skid_in_ready", busA.in_ready, 0);
        tick();
        checkOutput("skid_a_stable", busA.out_data, 32'h1);
        checkOutput("skid_a_tag", busA.out_tag, 1);
        busA.out_ready = 1'b1;
        tick();
        checkOutput("skid_b_data", busA.out_data, 32'h2);
        checkOutput("skid_b_tag", busA.out_tag, 2);
        checkOutput("skid_b_count", busA.xfer_count, 1);
        tick();
        checkOutput("skid_done_valid", busA.out_valid, 0);
        checkOutput("skid_done_count", busA.xfer_count, 2);

        // Flush from FULL with a drain and an offered input in the same cycle.
        applyStimulus(1'b1, 16'h0011, 2'd1, 5'd3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0022, 2'd1, 5'd4, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0033, 2'd1, 5'd5, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("flush_full_valid", busA.out_valid, 0);
        checkOutput("flush_full_ready", busA.in_ready, 1);
        checkOutput("flush_full_count", busA.xfer_count, 3);
        tick();
        checkOutput("flush_full_nothing", busA.out_valid, 0);

        // Flush from ONE while an input transfer happens: the input is lost.
        applyStimulus(1'b1, 16'h0044, 2'd1, 5'd6, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0055, 2'd1, 5'd7, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, 1'b0);
        checkOutput("flush_one_valid", busA.out_valid, 0);
        tick();
        checkOutput("flush_one_nothing", busA.out_valid, 0);
        checkOutput("flush_one_count", busA.xfer_count, 3);

        // Reset from FULL.
        applyStimulus(1'b1, 16'h00AA, 2'd0, 5'd9, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h00BB, 2'd0, 5'd10, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        checkOutput("rstfull_valid", busA.out_valid, 0);
        checkOutput("rstfull_data", busA.out_data, 0);
        checkOutput("rstfull_tag", busA.out_tag, 0);
        checkOutput("rstfull_count", busA.xfer_count, 0);
        reset = 1'b0;
        #1;
        checkOutput("rstfull_in_ready", busA.in_ready, 1);
        tick();
        checkOutput("rstfull_empty", busA.out_valid, 0);

        // Two-bit counter saturation on the second instance.
        cntExp[0] = 1; cntExp[1] = 2; cntExp[2] = 3; cntExp[3] = 3; cntExp[4] = 3;
        busC.in_valid  = 1'b1;
        busC.in_mode   = 2'd1;
        busC.in_imm    = 16'h0F0F;
        busC.out_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("sat_count%0d", i), busC.xfer_count, cntExp[i]);
        end
        busC.in_valid = 1'b0;

        // Random traffic against a FIFO scoreboard.
        applyReset();
        prevHeld = 1'b0;
        prevData = '0;
        prevTag  = '0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checkOutput("rnd_valid", busA.out_valid, modelQ.size() != 0);
            checkOutput("rnd_in_ready", busA.in_ready, modelQ.size() < 2);
            checkOutput("rnd_count", busA.xfer_count, modelCount);
            if (modelQ.size() != 0) begin
                checkOutput("rnd_data", busA.out_data, modelQ[0].data);
                checkOutput("rnd_tag", busA.out_tag, modelQ[0].tag);
            end
            if (prevHeld) begin
                checkOutput("rnd_stable_data", busA.out_data, prevData);
                checkOutput("rnd_stable_tag", busA.out_tag, prevTag);
            end

            applyStimulus($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom),
                          5'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
            inX  = busA.in_valid && (modelQ.size() < 2);
            outX = (modelQ.size() != 0) && busA.out_ready;
            prevHeld = (modelQ.size() != 0) && !busA.out_ready && !busA.flush;
            prevData = busA.out_data;
            prevTag  = busA.out_tag;
            e.data = refExt(busA.in_mode, busA.in_imm);
            e.tag  = busA.in_tag;
            tick();

            if (outX && modelCount < 65535) modelCount++;
            if (busA.flush) begin
                modelQ.delete();
            end else begin
                if (outX) void'(modelQ.pop_front());
                if (inX) modelQ.push_back(e);
            end
        end
        applyStimulus(1'b0, 16'h0, 2'd0, 5'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imm_extend_stage.md
IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 Parameter IN_W, default 16, immediate field width.
REQ-002 Parameter OUT_W, default 32, extended result width; OUT_W >= IN_W+2 SHALL hold, otherwise elaboration fails.
REQ-003 Parameter TAG_W, default 5, sideband tag width (e.g. destination register).
REQ-004 Parameter CNT_W, default 16, transfer-counter width.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  upstream holds a valid immediate.
REQ-008 in_ready  output  1  stage can accept an immediate.
REQ-009 in_imm  input  IN_W  raw immediate field.
REQ-010 in_mode  input  2  extension mode.
REQ-011 in_tag  input  TAG_W  sideband tag, carried unmodified.
REQ-012 flush  input  1  discard all held entries.
REQ-013 out_valid  output  1  out_data/out_tag valid.
REQ-014 out_ready  input  1  downstream accepts.
REQ-015 out_data  output  OUT_W  extended immediate.
REQ-016 out_tag  output  TAG_W  tag for out_data.
REQ-017 xfer_count  output  CNT_W  number of completed output transfers.

Function
REQ-018 Mode 00 (sign) SHALL produce in_imm with in_imm[IN_W-1] replicated into the upper OUT_W-IN_W bits.
REQ-019 Mode 01 (zero) SHALL produce in_imm with the upper OUT_W-IN_W bits at zero.
REQ-020 Mode 10 (upper) SHALL produce {in_imm, OUT_W-IN_W zero bits}.
REQ-021 Mode 11 (branch) SHALL produce the mode-00 result shifted left by 2, with the upper two bits discarded.
REQ-022 The extension SHALL be computed at input acceptance; stored entries hold the final result and tag.
REQ-023 Storage: one output register (out_valid) plus one skid register (skid_valid).
REQ-024 in_ready SHALL equal !skid_valid && !reset, combinationally.
REQ-025 Input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
REQ-026 Latency: an input accepted at edge N SHALL appear on out_* after edge N when the output register is empty or drains at edge N.
REQ-027 If the output register is full and does not drain at an input transfer, the entry SHALL go to the skid register.
REQ-028 On an output transfer with skid_valid=1, the skid entry SHALL move to the output register and skid_valid SHALL clear. A simultaneous input transfer is impossible because in_ready=0.
REQ-029 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush or reset.
REQ-030 out_data/out_tag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-031 flush=1 SHALL clear out_valid and skid_valid at the next edge.
  - Any input transfer in the same cycle is discarded.
  - xfer_count SHALL still count an output transfer occurring in that cycle.
REQ-032 xfer_count SHALL increment by 1 on each output transfer and saturate at all-ones.
REQ-033 State summary:
  - EMPTY (out_valid=0, skid_valid=0)
  - ONE (out_valid=1, skid_valid=0)
  - FULL (out_valid=1, skid_valid=1)
  - The state out_valid=0, skid_valid=1 SHALL be unreachable.

Reset
REQ-034 reset=1 at an edge SHALL set out_valid=0, skid_valid=0, out_data=0, out_tag=0 and xfer_count=0, overriding flush and all transfers.
REQ-035 Reset asserted mid-operation SHALL discard held entries, and the first cycle after deassertion SHALL show in_ready=1.

Verification
REQ-036 IN_W=16/OUT_W=32, out_ready=1: present imm 0x8004 in modes 00, 01, 10, 11 -> out_data = 0xFFFF8004, 0x00008004, 0x80040000, 0xFFFE0010 respectively, each one cycle after acceptance.
REQ-037 out_ready=0, send A=0x0001, B=0x0002 (mode 01) -> A held on out, B in skid, in_ready=0; raise out_ready -> A then B on consecutive cycles, xfer_count=2.
REQ-038 FULL state, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, xfer_count incremented by 1, flushed input never appears.
REQ-039 CNT_W=2, perform 5 transfers -> xfer_count sequence 1, 2, 3, 3, 3.
REQ-040 FULL state, assert reset for one cycle -> all outputs zero and out_valid=0; next cycle in_ready=1.
REQ-041 Random valid/ready/mode traffic, 10k cycles, against a reference-model scoreboard -> zero mismatches, order preserved, out_data stable under backpressure.
